// File: rtl/uart_rx_oversample.sv
// UART 8N1 receiver driven by a 16x oversampled baud level from the baud generator.
// It takes a 3-sample majority vote at mid-bit and hands bytes over on a valid/ready interface.
module uart_rx_oversample #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_baud,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int H  = OVERSAMPLE / 2;

  localparam logic [SW-1:0] CNT_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] CNT_SAMP0  = SW'(H - 1);
  localparam logic [SW-1:0] CNT_SAMP1  = SW'(H);
  localparam logic [SW-1:0] CNT_SAMP2  = SW'(H + 1);
  localparam logic [SW-1:0] CNT_DECIDE = SW'(H + 2);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } stateT;

  stateT                state;
  logic                 rxMeta;
  logic                 rxS;
  logic                 baudQ;
  logic                 tick;
  logic [SW-1:0]        sampleCnt;
  logic [BW-1:0]        bitCnt;
  logic [2:0]           sampleBits;
  logic                 majority;
  logic [DATA_BITS-1:0] shiftReg;

  // The synchronizer and the baud edge flop reset high, so a line that is idle at release gives no false start or tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
      baudQ  <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxS    <= rxMeta;
      baudQ  <= rx_baud;
    end
  end

  assign tick     = rx_baud & ~baudQ;
  assign majority = (sampleBits[0] & sampleBits[1]) |
                    (sampleBits[0] & sampleBits[2]) |
                    (sampleBits[1] & sampleBits[2]);

  // The receive FSM and all of its registered outputs. The stop bit is decided at mid-bit so a start bit that follows immediately is still caught.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sampleCnt  <= '0;
      bitCnt     <= '0;
      sampleBits <= '0;
      shiftReg   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (tick) begin
        if (state != IDLE) begin
          if (sampleCnt == CNT_SAMP0) sampleBits[0] <= rxS;
          if (sampleCnt == CNT_SAMP1) sampleBits[1] <= rxS;
          if (sampleCnt == CNT_SAMP2) sampleBits[2] <= rxS;
        end

        unique case (state)
          IDLE: begin
            if (!rxS) begin
              state     <= START;
              sampleCnt <= '0;
              busy      <= 1'b1;
            end
          end

          START: begin
            if (sampleCnt == CNT_LAST) begin
              sampleCnt <= '0;
              if (!majority) begin
                state <= DATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              sampleCnt <= sampleCnt + 1'b1;
            end
          end

          DATA: begin
            if (sampleCnt == CNT_LAST) begin
              sampleCnt <= '0;
              shiftReg  <= {majority, shiftReg[DATA_BITS-1:1]};
              if (bitCnt == BIT_LAST) begin
                bitCnt <= '0;
                state  <= STOP;
              end else begin
                bitCnt <= bitCnt + 1'b1;
              end
            end else begin
              sampleCnt <= sampleCnt + 1'b1;
            end
          end

          STOP: begin
            if (sampleCnt == CNT_DECIDE) begin
              sampleCnt <= '0;
              state     <= IDLE;
              busy      <= 1'b0;
              if (majority) begin
                rx_data  <= shiftReg;
                rx_valid <= 1'b1;
                overrun  <= rx_valid && !rx_ready;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              sampleCnt <= sampleCnt + 1'b1;
            end
          end

          default: begin
            state     <= IDLE;
            sampleCnt <= '0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
